multicycle_controller_p: RTL and testbench

MULTICYCLE_CONTROLLER_P -- requirements
Module: multicycle_controller_p

---
 rtl/multicycle_controller_p.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_controller_p.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_p.sv
// rtl/multicycle_controller_p.sv - Moore control FSM for a multicycle load/store datapath.
// Optional memory stall/timeout support: define MULTICYCLE_CONTROLLER_P_MEM_WAIT_EN.
module multicycle_controller_p #(
   parameter int IR_W     = 16,
   parameter int STATE_W  = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IR_W-1:0]    IR,
   input  logic               compare,
   input  logic               carry_flag,
   input  logic               zero_flag,
   input  logic               mem_ready,
   output logic [STATE_W-1:0] state_id,
   output logic [2:0]         alu_a_sel,
   output logic [1:0]         alu_b_sel,
   output logic [2:0]         rf_wadd_sel,
   output logic               rf_din_sel,
   output logic               alu_op,
   output logic               cz_en,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               rf_write,
   output logic               pc_write,
   output logic               bus_err
);

   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,
      S_DECODE   = 5'd1,
      S_EX_R     = 5'd2,
      S_EX_I     = 5'd3,
      S_EX_LHI   = 5'd4,
      S_WB_ALU   = 5'd5,
      S_MEM_ADDR = 5'd6,
      S_MEM_RD   = 5'd7,
      S_MEM_WR   = 5'd8,
      S_WB_MEM   = 5'd9,
      S_BR_CMP   = 5'd10,
      S_BR_TAKE  = 5'd11,
      S_JUMP     = 5'd12,
      S_ERR      = 5'd31
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1100;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] opcode;
   logic       is_rtype;
   logic       cond_ok;
   logic       adv;
   logic       timeout;
   logic       unused_ir;

   assign opcode    = IR[IR_W-1 -: 4];
   assign is_rtype  = (opcode == OP_ADD) || (opcode == OP_NDU);
   assign unused_ir = ^IR[IR_W-5:2];

   // Only ADD/NDU are predicated; condition code 11 behaves like 00.
   always_comb begin
      cond_ok = 1'b1;
      if (is_rtype) begin
         case (IR[1:0])
            2'b10:   cond_ok = carry_flag;
            2'b01:   cond_ok = zero_flag;
            default: cond_ok = 1'b1;
         endcase
      end
   end

`ifdef MULTICYCLE_CONTROLLER_P_MEM_WAIT_EN
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             mem_state;

   assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign adv       = mem_ready;
   // Fires on the WAIT_MAX-th consecutive stall cycle; a ready in that cycle still advances.
   assign timeout   = mem_state && !mem_ready && (wait_cnt == CNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (mem_state && !mem_ready)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   assign bus_err = (state == S_ERR);
`else
   logic unused_mem_ready;

   assign unused_mem_ready = mem_ready;
   assign adv              = 1'b1;
   assign timeout          = 1'b0;
   assign bus_err          = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: begin
            if (adv)          state_nxt = S_DECODE;
            else if (timeout) state_nxt = S_ERR;
         end
         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_NDU: state_nxt = S_EX_R;
               OP_ADI:         state_nxt = S_EX_I;
               OP_LHI:         state_nxt = S_EX_LHI;
               OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
               OP_BEQ:         state_nxt = S_BR_CMP;
               OP_JAL, OP_JLR: state_nxt = S_JUMP;
               default:        state_nxt = S_FETCH;
            endcase
         end
         S_EX_R, S_EX_I: state_nxt = S_WB_ALU;
         S_MEM_ADDR:     state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (adv)          state_nxt = S_WB_MEM;
            else if (timeout) state_nxt = S_ERR;
         end
         S_MEM_WR: begin
            if (adv)          state_nxt = S_FETCH;
            else if (timeout) state_nxt = S_ERR;
         end
         S_BR_CMP:       state_nxt = compare ? S_BR_TAKE : S_FETCH;
         S_ERR:          state_nxt = S_ERR;
         default:        state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      alu_a_sel   = 3'b000;
      alu_b_sel   = 2'b00;
      rf_wadd_sel = 3'b000;
      rf_din_sel  = 1'b0;
      alu_op      = 1'b0;
      cz_en       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      rf_write    = 1'b0;
      pc_write    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_a_sel = 3'b101;
            alu_b_sel = 2'b10;
         end
         S_EX_R: begin
            alu_op = (opcode == OP_NDU);
            cz_en  = 1'b1;
         end
         S_EX_I: cz_en = 1'b1;
         S_WB_ALU: begin
            rf_din_sel  = 1'b1;
            rf_wadd_sel = (opcode == OP_ADI) ? 3'b011 : 3'b001;
            rf_write    = cond_ok;
         end
         S_EX_LHI: begin
            rf_write   = 1'b1;
            rf_din_sel = 1'b1;
         end
         S_MEM_ADDR: begin
            alu_a_sel = 3'b011;
            alu_b_sel = 2'b10;
         end
         S_MEM_RD:  mem_read  = 1'b1;
         S_MEM_WR:  mem_write = 1'b1;
         S_WB_MEM:  rf_write  = 1'b1;
         S_BR_TAKE: pc_write  = 1'b1;
         S_JUMP: begin
            pc_write = 1'b1;
            rf_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_id = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller_p.sv
// tb/tb_multicycle_controller_p.sv - directed vector bench for multicycle_controller_p.
module tb_multicycle_controller_p;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] IR;
   logic        compare, carry_flag, zero_flag, mem_ready;
   logic [4:0]  state_id;
   logic [2:0]  alu_a_sel;
   logic [1:0]  alu_b_sel;
   logic [2:0]  rf_wadd_sel;
   logic        rf_din_sel, alu_op, cz_en, mem_read, mem_write;
   logic        ir_write, rf_write, pc_write, bus_err;

   int tests = 0;
   int fails = 0;

   multicycle_controller_p #(.IR_W(16), .STATE_W(5), .WAIT_MAX(15)) dut (
      .clk(clk), .reset(reset), .IR(IR), .compare(compare),
      .carry_flag(carry_flag), .zero_flag(zero_flag), .mem_ready(mem_ready),
      .state_id(state_id), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .rf_wadd_sel(rf_wadd_sel), .rf_din_sel(rf_din_sel), .alu_op(alu_op),
      .cz_en(cz_en), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .rf_write(rf_write), .pc_write(pc_write),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] ir;
      logic        carry;
      logic        zero;
      logic        cmp;
      logic [2:0]  len;
      logic [29:0] path;
      logic        wb_rf_write;
      logic [2:0]  wb_wadd;
      logic        wb_pc;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [29:0] pth(input logic [4:0] a, b, c, d, e, f);
      return {f, e, d, c, b, a};
   endfunction

   function automatic vec_t mk(input logic [15:0] ir, input logic carry, zero, cmp,
                               input logic [2:0] len, input logic [29:0] path,
                               input logic wrf, input logic [2:0] wadd, input logic wpc);
      vec_t v;
      v.ir = ir; v.carry = carry; v.zero = zero; v.cmp = cmp; v.len = len;
      v.path = path; v.wb_rf_write = wrf; v.wb_wadd = wadd; v.wb_pc = wpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ir, carry, zero, cmp, len, path, rf_write/wadd/pc_write in the last state before FETCH
      vecs[0]  = mk(16'h0000, 0, 0, 0, 5, pth(0, 1, 2, 5, 0, 0),   1, 3'b001, 0);
      vecs[1]  = mk(16'h0002, 0, 0, 0, 5, pth(0, 1, 2, 5, 0, 0),   0, 3'b001, 0);
      vecs[2]  = mk(16'h0002, 1, 0, 0, 5, pth(0, 1, 2, 5, 0, 0),   1, 3'b001, 0);
      vecs[3]  = mk(16'h2001, 1, 0, 0, 5, pth(0, 1, 2, 5, 0, 0),   0, 3'b001, 0);
      vecs[4]  = mk(16'h2003, 0, 0, 0, 5, pth(0, 1, 2, 5, 0, 0),   1, 3'b001, 0);
      vecs[5]  = mk(16'h1002, 0, 0, 0, 5, pth(0, 1, 3, 5, 0, 0),   1, 3'b011, 0);
      vecs[6]  = mk(16'h3000, 0, 0, 0, 4, pth(0, 1, 4, 0, 0, 0),   1, 3'b000, 0);
      vecs[7]  = mk(16'h4000, 0, 0, 0, 6, pth(0, 1, 6, 7, 9, 0),   1, 3'b000, 0);
      vecs[8]  = mk(16'h5000, 0, 0, 0, 5, pth(0, 1, 6, 8, 0, 0),   0, 3'b000, 0);
      vecs[9]  = mk(16'hC000, 0, 0, 1, 5, pth(0, 1, 10, 11, 0, 0), 0, 3'b000, 1);
      vecs[10] = mk(16'hC000, 0, 0, 0, 4, pth(0, 1, 10, 0, 0, 0),  0, 3'b000, 0);
      vecs[11] = mk(16'h8000, 0, 0, 0, 4, pth(0, 1, 12, 0, 0, 0),  1, 3'b000, 1);
      vecs[12] = mk(16'hF000, 0, 0, 0, 3, pth(0, 1, 0, 0, 0, 0),   0, 3'b000, 0);

      reset = 1'b1; IR = '0; compare = 0; carry_flag = 0; zero_flag = 0; mem_ready = 1'b1;
      #2;
      chk("rst_state",    32'(state_id),  0);
      chk("rst_fetch_ctl", {mem_read, ir_write, pc_write, alu_a_sel, alu_b_sel}, 32'b111_101_10);
      chk("rst_other",    {rf_write, mem_write, cz_en, alu_op, bus_err}, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         IR = vecs[i].ir; carry_flag = vecs[i].carry; zero_flag = vecs[i].zero;
         compare = vecs[i].cmp;
         chk($sformatf("v%0d_s0", i), 32'(state_id), 32'(vecs[i].path[4:0]));
         for (int k = 1; k < int'(vecs[i].len); k++) begin
            tick();
            chk($sformatf("v%0d_s%0d", i, k), 32'(state_id), 32'(vecs[i].path[5*k +: 5]));
            if (k == int'(vecs[i].len) - 2)
               chk($sformatf("v%0d_wb", i), {rf_write, rf_wadd_sel, pc_write},
                   {vecs[i].wb_rf_write, vecs[i].wb_wadd, vecs[i].wb_pc});
         end
      end

      // NDU datapath strobes
      IR = 16'h2000;
      tick(); tick();
      chk("ndu_ex", {alu_op, cz_en}, 2'b11);
      tick();
      chk("ndu_wb", {cz_en, rf_din_sel, rf_write}, 3'b011);
      tick();
      chk("ndu_done", 32'(state_id), 0);

      // LW: address phase, stalled read, write-back
      IR = 16'h4000;
      tick(); tick();
      chk("lw_addr", {alu_a_sel, alu_b_sel, mem_read}, 6'b011_10_0);
      mem_ready = 1'b0;
      tick();
      chk("lw_rd", {27'(state_id), mem_read}, {27'd7, 1'b1});
`ifdef MULTICYCLE_CONTROLLER_P_MEM_WAIT_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("lw_hold%0d", k), 32'(state_id), 7);
      end
      mem_ready = 1'b1;
`endif
      tick();
      chk("lw_wbmem", {27'(state_id), rf_din_sel, rf_write}, {27'd9, 2'b01});
      tick();
      chk("lw_done", 32'(state_id), 0);

      // Reset pulsed in MEM_WR drops mem_write without a clock edge
      mem_ready = 1'b1; IR = 16'h5000;
      tick(); tick(); tick();
      chk("sw_wr", {27'(state_id), mem_write}, {27'd8, 1'b1});
      #2 reset = 1'b1;
      #1;
      chk("sw_rst", {27'(state_id), mem_write, rf_write}, {27'd0, 2'b00});
      @(negedge clk);
      reset = 1'b0;

`ifdef MULTICYCLE_CONTROLLER_P_MEM_WAIT_EN
      // Ready on the final allowed stall cycle still advances
      IR = 16'hF000; mem_ready = 1'b0;
      for (int k = 0; k < 14; k++) tick();
      chk("race_hold", 32'(state_id), 0);
      mem_ready = 1'b1;
      tick();
      chk("race_ready_wins", 32'(state_id), 1);
      mem_ready = 1'b0;
      tick();
      chk("race_back", 32'(state_id), 0);
      for (int k = 0; k < 14; k++) tick();
      chk("to_14", {27'(state_id), bus_err}, {27'd0, 1'b0});
      tick();
      chk("to_err", {27'(state_id), bus_err}, {27'd31, 1'b1});
      chk("to_strobes", {mem_read, ir_write, pc_write, rf_write, mem_write}, 0);
      mem_ready = 1'b1;
      tick(); tick();
      chk("to_sticky", {27'(state_id), bus_err}, {27'd31, 1'b1});
      #2 reset = 1'b1;
      #1;
      chk("to_rst", {27'(state_id), bus_err}, {27'd0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
`else
      // mem_ready is ignored without the wait feature
      IR = 16'hF000; mem_ready = 1'b0;
      tick();
      chk("nowait_fetch", {27'(state_id), bus_err}, {27'd1, 1'b0});
      for (int k = 0; k < 20; k++) tick();
      chk("nowait_noerr", 32'(bus_err), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
